// File: rtl/eth_mdio_slave.sv
// Clause-22 MDIO responder with a 32 x 16-bit register file. MDC is sampled as data on Clk.
// Build option MDIO_BCAST_EN: writes addressed to PHYAD 0 are also accepted.

module eth_mdio_slave #(
    parameter logic [4:0] pPhy_Addr     = 5'd1,
    parameter int         pPreamble_Len = 32,
    parameter int         pSync_Stages  = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MDC,
    input  logic        MDIO_I,
    output logic        MDIO_O,
    output logic        MDIO_Oe,
    output logic        Reg_Wr_Strb,
    output logic [4:0]  Reg_Wr_Addr,
    output logic [15:0] Reg_Wr_Data,
    output logic        Busy
);

    typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, DATA, SKIP} state_t;

    localparam int            PW      = $clog2(pPreamble_Len + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(pPreamble_Len);

    state_t                  state, state_n;
    logic [pSync_Stages-1:0] mdc_sync, mdio_sync;
    logic                    bit_evt, bit_val;
    logic [PW-1:0]           pre_cnt;
    logic [4:0]              bit_cnt, cur_field, reg_addr;
    logic [3:0]              field_sr;
    logic                    op_read, addr_ok;
    logic [15:0]             shift_sr, wr_word;
    logic [15:0]             regs [32];
    logic                    mdio_o_n, mdio_oe_n, commit, soft_rst;

    function automatic logic [15:0] reg_default(input int idx);
        case (idx)
            0:       return 16'h3100;
            1:       return 16'h7849;
            2:       return 16'h0007;
            3:       return 16'hC0F1;
            default: return 16'h0000;
        endcase
    endfunction

    // Synchronisers are deliberately unreset so a reset with MDC high creates no bit event.
    always_ff @(posedge Clk) begin
        mdc_sync  <= {mdc_sync[pSync_Stages-2:0], MDC};
        mdio_sync <= {mdio_sync[pSync_Stages-2:0], MDIO_I};
    end

    assign bit_evt   = mdc_sync[pSync_Stages-2] & ~mdc_sync[pSync_Stages-1];
    assign bit_val   = mdio_sync[pSync_Stages-1];
    assign cur_field = {field_sr, bit_val};
    assign wr_word   = {shift_sr[14:0], bit_val};
    assign Busy      = (state != IDLE);
    assign soft_rst  = commit && (reg_addr == 5'd0) && wr_word[15];

`ifdef MDIO_BCAST_EN
    assign addr_ok = (cur_field == pPhy_Addr) || ((cur_field == 5'd0) && !op_read);
`else
    assign addr_ok = (cur_field == pPhy_Addr);
`endif

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bit_evt) begin
            case (state)
                IDLE:  if (!bit_val && pre_cnt == PRE_MAX) state_n = ST;
                ST:    state_n = bit_val ? OP : IDLE;
                OP:    if (bit_cnt == 5'd1)
                           state_n = (cur_field[1] != cur_field[0]) ? PHYAD : IDLE;
                PHYAD: if (bit_cnt == 5'd4) state_n = addr_ok ? REGAD : SKIP;
                REGAD: if (bit_cnt == 5'd4) state_n = TA;
                TA: begin
                    if (op_read) begin
                        if (bit_cnt == 5'd1) state_n = DATA;
                    end else if (bit_cnt == 5'd0) begin
                        if (!bit_val) state_n = IDLE;
                    end else begin
                        state_n = bit_val ? IDLE : DATA;
                    end
                end
                DATA:    if (bit_cnt == 5'd15) state_n = IDLE;
                SKIP:    if (bit_cnt == 5'd17) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Read data leaves one bit event ahead of the master's sample point.
    always_comb begin
        mdio_o_n  = MDIO_O;
        mdio_oe_n = MDIO_Oe;
        commit    = 1'b0;
        if (bit_evt) begin
            if (state == TA && op_read) begin
                if (bit_cnt == 5'd0) begin
                    mdio_oe_n = 1'b1;
                    mdio_o_n  = 1'b0;
                end else begin
                    mdio_o_n = regs[reg_addr][15];
                end
            end else if (state == DATA && op_read) begin
                if (bit_cnt == 5'd15) begin
                    mdio_oe_n = 1'b0;
                    mdio_o_n  = 1'b1;
                end else begin
                    mdio_o_n = shift_sr[15];
                end
            end else if (state == DATA && bit_cnt == 5'd15) begin
                commit = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            MDIO_O      <= 1'b1;
            MDIO_Oe     <= 1'b0;
            Reg_Wr_Strb <= 1'b0;
            Reg_Wr_Addr <= '0;
            Reg_Wr_Data <= '0;
            pre_cnt     <= '0;
            bit_cnt     <= '0;
            field_sr    <= '0;
            reg_addr    <= '0;
            op_read     <= 1'b0;
            shift_sr    <= '0;
        end else begin
            MDIO_O      <= mdio_o_n;
            MDIO_Oe     <= mdio_oe_n;
            Reg_Wr_Strb <= commit;
            if (commit) begin
                Reg_Wr_Addr <= reg_addr;
                Reg_Wr_Data <= wr_word;
            end
            if (state != IDLE) pre_cnt <= '0;
            if (bit_evt) begin
                field_sr <= cur_field[3:0];
                bit_cnt  <= (state_n != state) ? 5'd0 : bit_cnt + 5'd1;
                if (state == IDLE) begin
                    if (!bit_val)                pre_cnt <= '0;
                    else if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + PW'(1);
                end
                if (state == OP && bit_cnt == 5'd1)    op_read  <= cur_field[1];
                if (state == REGAD && bit_cnt == 5'd4) reg_addr <= cur_field;
                if (state == TA && op_read && bit_cnt == 5'd1)
                    shift_sr <= {regs[reg_addr][14:0], 1'b0};
                else if (state == DATA)
                    shift_sr <= op_read ? {shift_sr[14:0], 1'b0} : wr_word;
            end
        end
    end

    // Registers 1-3 are read-only; soft reset through reg0 bit 15 restores the whole file.
    for (genvar g = 0; g < 32; g++) begin : g_regs
        localparam logic [15:0] DFLT = reg_default(g);
        always_ff @(posedge Clk) begin
            if (Rst || soft_rst)
                regs[g] <= DFLT;
            else if (commit && reg_addr == 5'(g) && (g == 0 || g > 3))
                regs[g] <= wr_word;
        end
    end

endmodule
